// File: rtl/seq_div_restoring_pkg.sv
// seq_div_restoring_pkg: shared state encoding, default widths and width helper
package seq_div_restoring_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ZDIV = 2'd2
    } state_t;
    localparam int NW_DEFAULT = 9;
    localparam int DW_DEFAULT = 4;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/seq_div_restoring_div_step.sv
// div_step: one combinational restoring-division step at DW+1 bits
module div_step #(
    parameter int DW = 4
) (
    input  logic [DW:0]   rIn,
    input  logic          bitIn,
    input  logic [DW-1:0] d,
    output logic [DW:0]   rOut,
    output logic          qBit
);
    logic [DW:0] trial;
    logic        unusedGuard;
    // the guard bit of rIn is always 0 after a restoring step, so it is shifted out
    assign unusedGuard = rIn[DW];
    assign trial = {rIn[DW-1:0], bitIn};
    assign qBit  = trial >= {1'b0, d};
    assign rOut  = qBit ? trial - {1'b0, d} : trial;
endmodule

// File: rtl/seq_div_restoring.sv
// seq_div_restoring: unsigned restoring divider, one quotient bit per clock,
// with start/busy/done handshake and a divide-by-zero shortcut state
module seq_div_restoring
    import seq_div_restoring_pkg::*;
#(
    parameter int NW = NW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clkP,
    input  logic          resN,
    input  logic          start,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          divByZero
);
    localparam int CW = clog2(NW);
    state_t        state, stateNext;
    logic [NW-1:0] qReg, qStep;
    logic [DW-1:0] dReg;
    logic [DW:0]   rReg, rStep;
    logic [CW-1:0] cnt;
    logic          qBit;

    div_step #(.DW(DW)) uStep (
        .rIn(rReg),
        .bitIn(qReg[NW-1]),
        .d(dReg),
        .rOut(rStep),
        .qBit(qBit)
    );

    assign qStep = {qReg[NW-2:0], qBit};
    assign busy  = state != ST_IDLE;

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: if (start) stateNext = (divisor == '0) ? ST_ZDIV : ST_RUN;
            ST_RUN:  if (cnt == '0) stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkP or negedge resN) begin
        if (!resN) state <= ST_IDLE;
        else       state <= stateNext;
    end

    always_ff @(posedge clkP or negedge resN) begin
        if (!resN) begin
            qReg      <= '0;
            dReg      <= '0;
            rReg      <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            divByZero <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE && start && divisor != '0) begin
                qReg <= dividend;
                dReg <= divisor;
                rReg <= '0;
                cnt  <= CW'(NW - 1);
            end else if (state == ST_RUN) begin
                qReg <= qStep;
                rReg <= rStep;
                if (cnt == '0) begin
                    quotient  <= qStep;
                    remainder <= rStep[DW-1:0];
                    divByZero <= 1'b0;
                    done      <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end else if (state == ST_ZDIV) begin
                quotient  <= '1;
                remainder <= '0;
                divByZero <= 1'b1;
                done      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_div_restoring.sv
// tb_seq_div_restoring: directed and random checks of the divider against a
// cycle-level behavioural model built from plain integer division
module tb_seq_div_restoring;
    localparam int NW = 9;
    localparam int DW = 4;

    logic          clkP = 1'b0;
    logic          resN = 1'b0;
    logic          start = 1'b0;
    logic [NW-1:0] dividend = '0;
    logic [DW-1:0] divisor = '0;
    logic          busy, done, divByZero;
    logic [NW-1:0] quotient;
    logic [DW-1:0] remainder;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    seq_div_restoring #(.NW(NW), .DW(DW)) dut (
        .clkP(clkP),
        .resN(resN),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .divByZero(divByZero)
    );

    always #5 clkP = ~clkP;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // behavioural model: an accepted request completes a fixed number of edges later
    bit            mBusy, mDone, mZ, pz;
    int            mLeft;
    logic [NW-1:0] mQ, pq;
    logic [DW-1:0] mR, pr;

    always @(posedge clkP or negedge resN) begin
        if (!resN) begin
            mBusy = 0; mDone = 0; mZ = 0; pz = 0; mLeft = 0;
            mQ = '0; mR = '0; pq = '0; pr = '0;
        end else begin
            mDone = 0;
            if (mBusy) begin
                mLeft--;
                if (mLeft == 0) begin
                    mBusy = 0; mDone = 1; mQ = pq; mR = pr; mZ = pz;
                end
            end else if (start) begin
                mBusy = 1;
                if (divisor == '0) begin
                    mLeft = 1; pq = '1; pr = '0; pz = 1;
                end else begin
                    mLeft = NW;
                    pq = dividend / NW'(divisor);
                    pr = DW'(dividend % NW'(divisor));
                    pz = 0;
                end
            end
        end
    end

    always @(negedge clkP) begin
        if (resN && checking) begin
            check("busy", 32'(busy), 32'(mBusy));
            check("done", 32'(done), 32'(mDone));
            check("quotient", 32'(quotient), 32'(mQ));
            check("remainder", 32'(remainder), 32'(mR));
            check("divByZero", 32'(divByZero), 32'(mZ));
        end
    end

    task automatic waitDone(input bit dropStart, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clkP);
            n++;
            if (dropStart && n == 1) start = 1'b0;
            if (done) return;
        end
        n = -1;
    endtask

    task automatic doDiv(input int n, input int d, input int eq, input int er, input int ez, input int lat, input string name);
        int cyc;
        @(negedge clkP);
        start = 1'b1; dividend = NW'(n); divisor = DW'(d);
        waitDone(1'b1, cyc);
        check({name, "_lat"}, 32'(cyc), 32'(lat));
        check({name, "_q"}, 32'(quotient), 32'(eq));
        check({name, "_r"}, 32'(remainder), 32'(er));
        check({name, "_z"}, 32'(divByZero), 32'(ez));
    endtask

    initial begin
        int cyc, cnt, curN, curD;
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_q", 32'(quotient), 0);
        check("rst_r", 32'(remainder), 0);
        check("rst_z", 32'(divByZero), 0);
        @(negedge clkP);
        resN = 1'b1;
        checking = 1'b1;

        doDiv(200, 7, 28, 4, 0, NW + 1, "basic");
        @(negedge clkP);
        check("basic_done_low", 32'(done), 0);
        doDiv(511, 15, 34, 1, 0, NW + 1, "max");
        doDiv(5, 9, 0, 5, 0, NW + 1, "small");
        doDiv(0, 3, 0, 0, 0, NW + 1, "zero_n");
        doDiv(9, 1, 9, 0, 0, NW + 1, "div1");
        doDiv(123, 0, 511, 0, 1, 2, "dbz");
        doDiv(20, 4, 5, 0, 0, NW + 1, "after_dbz");

        // start while busy must be ignored
        @(negedge clkP);
        start = 1'b1; dividend = 9'd100; divisor = 4'd3;
        @(negedge clkP);
        start = 1'b0;
        repeat (2) @(negedge clkP);
        start = 1'b1; dividend = 9'd50; divisor = 4'd5;
        @(negedge clkP);
        start = 1'b0;
        waitDone(1'b0, cyc);
        check("busy_ign_lat", 32'(cyc), 32'(NW + 1 - 4));
        check("busy_ign_q", 32'(quotient), 33);
        check("busy_ign_r", 32'(remainder), 1);
        cnt = 0;
        repeat (15) begin
            @(negedge clkP);
            if (done) cnt++;
        end
        check("busy_ign_extra_done", 32'(cnt), 0);

        // asynchronous reset in the middle of an operation
        @(negedge clkP);
        start = 1'b1; dividend = 9'd200; divisor = 4'd7;
        @(negedge clkP);
        start = 1'b0;
        repeat (4) @(posedge clkP);
        #2 resN = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_q", 32'(quotient), 0);
        check("mid_rst_r", 32'(remainder), 0);
        check("mid_rst_z", 32'(divByZero), 0);
        @(negedge clkP);
        resN = 1'b1;
        doDiv(77, 6, 12, 5, 0, NW + 1, "post_rst");

        // back-to-back random operands, start held high through each done cycle
        @(negedge clkP);
        curN = int'($urandom_range(0, (1 << NW) - 1));
        curD = int'($urandom_range(1, (1 << DW) - 1));
        start = 1'b1; dividend = NW'(curN); divisor = DW'(curD);
        for (int i = 0; i < 500; i++) begin
            waitDone(1'b0, cyc);
            check("b2b_spacing", 32'(cyc), 32'(NW + 1));
            check("b2b_invariant", 32'(int'(quotient) * curD + int'(remainder)), 32'(curN));
            check("b2b_rem_lt_d", 32'(int'(remainder) < curD), 1);
            curN = int'($urandom_range(0, (1 << NW) - 1));
            curD = int'($urandom_range(1, (1 << DW) - 1));
            dividend = NW'(curN); divisor = DW'(curD);
            if (cyc < 0) break;
        end
        start = 1'b0;
        repeat (NW + 3) @(negedge clkP);
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
